// File: rtl/pingpong_input_buffer.sv
// pingpong_input_buffer
// Two-bank pixel window buffer between the pixel source and the GAN compute
// datapath. One bank fills while compute reads the other. Each window is handed
// to compute with a valid/ack handshake.
// Optional feature macro: PINGPONG_INBUF_DROP_CNT_EN. When defined, it adds a
// saturating 16-bit drop_cnt output that counts stalled in_valid cycles.
module pingpong_input_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ack,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  output logic                        out_bank,
  output logic [CNT_W-1:0]            wr_level
`ifdef PINGPONG_INBUF_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] bank_q [2][DEPTH];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]      wr_count_q, wr_count_d;

  logic accept;
  logic ack_fire;
  logic last_pix;

  // All handshake outputs come straight from registered state.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_bank  = rd_bank_q;
  assign wr_level  = wr_count_q;

  assign accept   = in_valid & in_ready;
  assign ack_fire = out_ack & out_valid;
  assign last_pix = (wr_count_q == CNT_W'(DEPTH - 1));

  // Present the whole read bank as one flat word. Pixel 0 is in the low bits.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = bank_q[rd_bank_q][i];
    end
  end

  // Compute the next bank flags and pointers.
  // An ack and a fill in the same cycle always touch different banks.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_count_d = wr_count_q;
    if (ack_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (accept) begin
      if (last_pix) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_count_d        = '0;
      end else begin
        wr_count_d = wr_count_q + CNT_W'(1);
      end
    end
  end

  // Update the state and write the pixel.
  // rst and clear both flush the banks, so out_data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_count_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_count_q <= wr_count_d;
      if (accept) begin
        bank_q[wr_bank_q][wr_count_q[AW-1:0]] <= in_data;
      end
    end
  end

`ifdef PINGPONG_INBUF_DROP_CNT_EN
  logic [15:0] drop_q;

  assign drop_cnt = drop_q;

  // Count the cycles where the source offers a pixel but is stalled.
  // The count saturates at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  // Stall counter not built; the core buffer above is unaffected.
`endif

endmodule

// File: tb/tb_pingpong_input_buffer.sv
// Randomized self-checking bench for pingpong_input_buffer.
// The reference model is a queue of completed windows plus a partial window.
module tb_pingpong_input_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [DEPTH*DW-1:0] win_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ack = 1'b0;
  win_t             out_data;
  logic             out_bank;
  logic [CNT_W-1:0] wr_level;
`ifdef PINGPONG_INBUF_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  pingpong_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .out_bank  (out_bank),
    .wr_level  (wr_level)
`ifdef PINGPONG_INBUF_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  win_t          m_full[$];
  logic [DW-1:0] m_part[$];
  bit            m_rd;
  int            m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full.delete();
    m_part.delete();
    m_rd    = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(m_full.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(m_full.size() > 0));
    chk("out_bank", 64'(out_bank), 64'(m_rd));
    chk("wr_level", 64'(wr_level), 64'(m_part.size()));
    if (m_full.size() > 0) chk("out_data", 64'(out_data), 64'(m_full[0]));
`ifdef PINGPONG_INBUF_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model, then check the outputs.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit a, input bit c);
    bit   acc;
    bit   ackf;
    win_t w;
    in_valid = v;
    in_data  = d;
    out_ack  = a;
    clear    = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      acc  = v && (m_full.size() < 2);
      ackf = a && (m_full.size() > 0);
      if (v && !acc && m_drops < 65535) m_drops++;
      if (ackf) begin
        void'(m_full.pop_front());
        m_rd = !m_rd;
      end
      if (acc) begin
        m_part.push_back(d);
        if (m_part.size() == DEPTH) begin
          w = '0;
          for (int i = 0; i < DEPTH; i++) w[i*DW +: DW] = m_part[i];
          m_full.push_back(w);
          m_part.delete();
        end
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ack  = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check_outputs();
    chk("rst_out_data", 64'(out_data), 64'd0);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // A single window.
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    cycle(1, 8'h44, 0, 0);
    chk("win_data", 64'(out_data), 64'h44332211);
    chk("win_valid", 64'(out_valid), 64'd1);
    chk("win_bank", 64'(out_bank), 64'd0);
    chk("win_ready", 64'(in_ready), 64'd1);

    // Backpressure: nine pixels and no ack.
    do_reset();
    for (int i = 1; i <= 9; i++) cycle(1, 8'(i), 0, 0);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_level", 64'(wr_level), 64'd0);
    cycle(1, 8'd9, 1, 0);
    chk("bp_ack_bank", 64'(out_bank), 64'd1);
    chk("bp_ack_ready", 64'(in_ready), 64'd1);
    cycle(1, 8'd9, 0, 0);
    chk("bp_9th_level", 64'(wr_level), 64'd1);
    chk("bp_bank1_data", 64'(out_data), 64'h08070605);

    // Fill and ack in the same cycle.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'hA0 + i), 0, 0);
    cycle(1, 8'hA7, 1, 0);
    chk("sim_valid", 64'(out_valid), 64'd1);
    chk("sim_bank", 64'(out_bank), 64'd1);
    chk("sim_data", 64'(out_data), 64'hA7A6A5A4);
    chk("sim_ready", 64'(in_ready), 64'd1);

    // Clear in the middle of a window.
    do_reset();
    cycle(1, 8'h01, 0, 0);
    cycle(1, 8'h02, 0, 0);
    cycle(1, 8'hEE, 0, 1);
    chk("clr_level", 64'(wr_level), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h50 + i), 0, 0);
    chk("clr_next_win", 64'(out_data), 64'h53525150);

`ifdef PINGPONG_INBUF_DROP_CNT_EN
    // Drop counter.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'hFF, 0, 0);
    chk("drop_five", 64'(drop_cnt), 64'd5);
    cycle(0, 8'h00, 0, 1);
    chk("drop_clear", 64'(drop_cnt), 64'd0);
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3,
            $urandom_range(0, 199) == 0);
    end

    // Sustained full rate with an ack every window.
    do_reset();
    for (int n = 0; n < 64; n++) begin
      cycle(1, 8'($urandom), (n % DEPTH) == 0, 0);
      chk("rate_ready", 64'(in_ready), 64'd1);
    end

    in_valid = 1'b0;
    out_ack  = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_input_buffer.md
# pingpong_input_buffer

Double-banked (ping-pong) successor to the single-shot pixel input buffer, sitting between the pixel streaming source and the GAN compute datapath. It collects DEPTH pixels per window into one bank while the compute engine reads the other bank in parallel, which removes the per-window stall. Window hand-off to compute uses an explicit valid/ack handshake instead of an FSM-driven clear.

## Interface
- DATA_WIDTH, 8, pixel bit width
- DEPTH, 4, pixels per window (N*N); must be at least 2
- CNT_W, $clog2(DEPTH)+1, width of the fill counter
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- clear  in  1  synchronous flush of both banks and all pointers
- in_valid  in  1  source has a pixel on in_data
- in_data  in  DATA_WIDTH  pixel
- in_ready  out  1  buffer accepts a pixel this cycle
- out_valid  out  1  the bank at rd_bank holds a complete window
- out_ack  in  1  compute has finished with the presented window
- out_data  out  DEPTH*DATA_WIDTH  presented window; pixel i is in bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_bank  out  1  index of the presented bank (debug/trace)
- wr_level  out  CNT_W  number of pixels written into the current write bank

## Operation
- State:
  - two banks of DEPTH words
  - bank_full[1:0]
  - wr_bank
  - rd_bank
  - wr_count (0..DEPTH-1)
- Write rule:
  - in_ready = !bank_full[wr_bank].
  - A pixel is accepted when in_valid && in_ready. It is written to bank[wr_bank][wr_count], and wr_count increments.
  - On the accept with wr_count==DEPTH-1: set bank_full[wr_bank], toggle wr_bank, and set wr_count to 0 (wrap).
- Read rule:
  - out_valid = bank_full[rd_bank].
  - out_data = bank[rd_bank].
  - When out_ack && out_valid: clear bank_full[rd_bank] and toggle rd_bank.
  - When out_ack && !out_valid: ignored, no state change.
- Ordering: windows are presented strictly in fill order. rd_bank only advances on ack, and wr_bank only advances on fill.
- Fill and ack in the same cycle:
  - Both take effect.
  - They always target different banks: a full rd_bank is never the write target.
- Both banks full: in_ready=0, and in_valid is held off with no data loss. The source must hold in_data until it is accepted.
- wr_level = wr_count.
- Priority is rst > clear > normal operation.
- clear and rst both:
  - zero both banks;
  - set bank_full=0, wr_bank=0, rd_bank=0, wr_count=0.
- A partial window in progress at clear or rst is discarded.
- Arithmetic: wr_count is CNT_W bits wide and never exceeds DEPTH-1. Bank index arithmetic is modulo 2.

## Timing
- Reset values of outputs:
  - in_ready=1
  - out_valid=0
  - out_data=0
  - out_bank=0
  - wr_level=0
- in_ready, out_valid and out_data are driven only from registers. There is no combinational path from in_valid or out_ack.
- Latency: the last pixel of a window accepted at edge k gives out_valid=1 in the cycle after edge k.
- After an ack at edge k:
  - out_valid reflects the other bank after edge k;
  - a freed bank raises in_ready after edge k.
- Throughput: sustains one pixel per cycle indefinitely if out_ack is asserted at least once per DEPTH cycles.
- Without ack, 2*DEPTH pixels are accepted back-to-back, then in_ready falls.
- clear takes effect at the edge where it is sampled. An in_valid in that same cycle is dropped.

## Configuration
- Macro: PINGPONG_INBUF_DROP_CNT_EN.
- When defined:
  - adds output drop_cnt, 16 bits;
  - drop_cnt counts cycles with in_valid && !in_ready;
  - it saturates at 16'hFFFF;
  - it is zeroed by rst and by clear.
- When undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Reset state.** Assert rst 2 cycles -> in_ready=1, out_valid=0, wr_level=0, out_data=0.
- **Single window.** Stream pixels 8'h11,22,33,44 back-to-back -> out_valid=1 the cycle after the 4th accept; out_data=32'h44332211; out_bank=0; in_ready stays 1.
- **Backpressure.** Stream 9 pixels with out_ack held 0 -> the first 8 are accepted, in_ready=0 from cycle 9; the 9th is held. Pulse out_ack -> out_bank=1; in_ready=1 next cycle; the 9th pixel lands in bank 0 with wr_level=1.
- **Simultaneous fill and ack.** Bank 0 is full. Accept the 4th pixel of bank 1 in the same cycle as out_ack -> bank 1 is presented next cycle with out_valid=1; bank_full=2'b10.
- **Mid-window clear.** Write 2 pixels, then assert clear together with in_valid -> wr_level=0, out_valid=0, out_data=0; the pixel presented in the clear cycle is dropped.
- **Drop counter (macro defined).** Both banks full; hold in_valid 5 cycles -> drop_cnt=5. Then clear -> drop_cnt=0.
